// File: rtl/SH7034_PKG.sv
// Shared SH7034 bus-emulation types: external target FSM states and the
// data value returned when a backend access is forced to complete.
package SH7034_PKG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } ExtTgtState_t;

  localparam logic [15:0] EXT_TGT_FF_DATA = 16'hFFFF;

endpackage

// File: rtl/sh_ext_bus_target.sv
// SH7034 external-bus chip-select responder: one strobe cycle -> one backend req/ack.
// Define EXT_TGT_TIMEOUT_EN to force completion (and pulse ERR) when the backend stalls.
module sh_ext_bus_target
  import SH7034_PKG::*;
#(
  parameter int unsigned BUS16    = 1,
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [23:0] A,
  input  logic [15:0] BUS_DI,
  output logic [15:0] BUS_DO,
  output logic        BUS_OE,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic [1:0]  WE_N,
  output logic        WAIT_N,
  output logic [23:0] MEM_A,
  output logic [15:0] MEM_DO,
  input  logic [15:0] MEM_DI,
  output logic [1:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  output logic        ERR
);

  // state | meaning
  // IDLE  | no access; a strobe seen on CE_F starts one
  // REQ   | backend request outstanding and/or minimum wait still running
  // HOLD  | access served, read data held until the strobes rise
  ExtTgtState_t state_q, state_d;

  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        acked_q, acked_d;
  logic        abort_q, abort_d;
  logic [15:0] bus_do_q, bus_do_d;
  logic        bus_oe_q, bus_oe_d;
  logic        wait_n_q, wait_n_d;
  logic [23:0] mem_a_q, mem_a_d;
  logic [15:0] mem_do_q, mem_do_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_req_q, mem_req_d;

  logic        stb;
  logic        ack_now;
  logic        timeout_now;
  logic        done;
  logic        abort_now;
  logic [2:0]  wait_dec;
  logic [15:0] rd_data;
  logic [15:0] wr_data;
  logic        unused_ce_r;

  assign unused_ce_r = CE_R;

  assign stb       = !CS_N && (!RD_N || (WE_N != 2'b11));
  assign ack_now   = (state_q == REQ) && mem_req_q && MEM_ACK;
  assign done      = acked_q || ack_now || timeout_now;
  assign abort_now = abort_q || !stb;
  assign wait_dec  = (wait_cnt_q != 3'd0) ? (wait_cnt_q - 3'd1) : 3'd0;
  assign rd_data   = (BUS16 != 0) ? MEM_DI : {8'h00, MEM_DI[7:0]};
  assign wr_data   = (BUS16 != 0) ? BUS_DI : {8'h00, BUS_DI[7:0]};

`ifdef EXT_TGT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q;

  // Counts CE_F periods spent in REQ before any acknowledge.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_now = 1'b0;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if ((state_q == REQ) && CE_F && !acked_q && !ack_now) begin
      to_cnt_d    = to_cnt_q + 1'b1;
      timeout_now = (({1'b0, to_cnt_q} + 1'b1) == (TO_W + 1)'(TIMEOUT));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= timeout_now;
    end
  end

  assign ERR = err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT;

  assign timeout_now = 1'b0;
  assign ERR         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    acked_d    = acked_q;
    abort_d    = abort_q;
    bus_do_d   = bus_do_q;
    bus_oe_d   = bus_oe_q;
    wait_n_d   = wait_n_q;
    mem_a_d    = mem_a_q;
    mem_do_d   = mem_do_q;
    mem_be_d   = mem_be_q;
    mem_we_d   = mem_we_q;
    mem_req_d  = mem_req_q;

    unique case (state_q)
      IDLE: begin
        if (CE_F && stb) begin
          mem_a_d    = A;
          mem_we_d   = RD_N;
          mem_do_d   = wr_data;
          mem_be_d   = (BUS16 != 0) ? (RD_N ? ~WE_N : 2'b11) : 2'b01;
          mem_req_d  = 1'b1;
          wait_n_d   = 1'b0;
          wait_cnt_d = 3'(MIN_WAIT);
          acked_d    = 1'b0;
          abort_d    = 1'b0;
          state_d    = REQ;
        end
      end

      REQ: begin
        if (!stb) begin
          abort_d = 1'b1;
        end
        if (ack_now) begin
          mem_req_d = 1'b0;
          acked_d   = 1'b1;
          if (!mem_we_q && !abort_now) begin
            bus_do_d = rd_data;
          end
        end
        if (timeout_now) begin
          mem_req_d = 1'b0;
          acked_d   = 1'b1;
          if (!mem_we_q && !abort_now) begin
            bus_do_d = EXT_TGT_FF_DATA;
          end
        end
        if (CE_F) begin
          wait_cnt_d = wait_dec;
          // An aborted access returns straight to IDLE once the backend is done.
          if (done && abort_now) begin
            wait_n_d = 1'b1;
            bus_oe_d = 1'b0;
            state_d  = IDLE;
          end else if (done && (wait_dec == 3'd0)) begin
            wait_n_d = 1'b1;
            bus_oe_d = !mem_we_q;
            state_d  = HOLD;
          end
        end
      end

      HOLD: begin
        // CS_N may stay low across split cycles, so the end is taken from the strobes.
        if (CE_F && RD_N && (WE_N == 2'b11)) begin
          bus_oe_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      wait_cnt_q <= 3'd0;
      acked_q    <= 1'b0;
      abort_q    <= 1'b0;
      bus_do_q   <= 16'h0000;
      bus_oe_q   <= 1'b0;
      wait_n_q   <= 1'b1;
      mem_a_q    <= 24'h000000;
      mem_do_q   <= 16'h0000;
      mem_be_q   <= 2'b00;
      mem_we_q   <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      acked_q    <= acked_d;
      abort_q    <= abort_d;
      bus_do_q   <= bus_do_d;
      bus_oe_q   <= bus_oe_d;
      wait_n_q   <= wait_n_d;
      mem_a_q    <= mem_a_d;
      mem_do_q   <= mem_do_d;
      mem_be_q   <= mem_be_d;
      mem_we_q   <= mem_we_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign BUS_DO  = bus_do_q;
  assign BUS_OE  = bus_oe_q;
  assign WAIT_N  = wait_n_q;
  assign MEM_A   = mem_a_q;
  assign MEM_DO  = mem_do_q;
  assign MEM_BE  = mem_be_q;
  assign MEM_WE  = mem_we_q;
  assign MEM_REQ = mem_req_q;

endmodule

// File: tb/tb_sh_ext_bus_target.sv
// Bench for sh_ext_bus_target: a 16-bit area (MIN_WAIT=0) and an 8-bit area (MIN_WAIT=3)
// on one shared CPU bus; the timeout sequence runs when EXT_TGT_TIMEOUT_EN is defined.
module tb_sh_ext_bus_target;

  localparam int MW [2] = '{0, 3};

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_R = 1'b0;
  logic        CE_F = 1'b0;
  logic [23:0] A = '0;
  logic [15:0] BUS_DI = '0;
  logic        RD_N = 1'b1;
  logic [1:0]  WE_N = 2'b11;

  logic        cs_n    [2];
  logic        mem_ack [2];
  logic [15:0] mem_di  [2];
  logic [15:0] bus_do  [2];
  logic        bus_oe  [2];
  logic        wait_n  [2];
  logic [23:0] mem_a   [2];
  logic [15:0] mem_do  [2];
  logic [1:0]  mem_be  [2];
  logic        mem_we  [2];
  logic        mem_req [2];
  logic        err     [2];

  int          checks = 0;
  int          errors = 0;
  int          ph = 0;
  logic [15:0] last_rd [2];

  always #5 CLK = ~CLK;

  // Bus clock = CLK/4: CE_R on phase 0, CE_F on phase 2.
  always @(negedge CLK) begin
    ph   = (ph + 1) % 4;
    CE_R = (ph == 0);
    CE_F = (ph == 2);
  end

  sh_ext_bus_target #(.BUS16(1), .MIN_WAIT(0), .TIMEOUT(4)) u_w16 (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .BUS_DI(BUS_DI),
    .BUS_DO(bus_do[0]), .BUS_OE(bus_oe[0]), .CS_N(cs_n[0]), .RD_N(RD_N), .WE_N(WE_N),
    .WAIT_N(wait_n[0]), .MEM_A(mem_a[0]), .MEM_DO(mem_do[0]), .MEM_DI(mem_di[0]),
    .MEM_BE(mem_be[0]), .MEM_WE(mem_we[0]), .MEM_REQ(mem_req[0]), .MEM_ACK(mem_ack[0]),
    .ERR(err[0]));

  sh_ext_bus_target #(.BUS16(0), .MIN_WAIT(3), .TIMEOUT(4)) u_w8 (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .BUS_DI(BUS_DI),
    .BUS_DO(bus_do[1]), .BUS_OE(bus_oe[1]), .CS_N(cs_n[1]), .RD_N(RD_N), .WE_N(WE_N),
    .WAIT_N(wait_n[1]), .MEM_A(mem_a[1]), .MEM_DO(mem_do[1]), .MEM_DI(mem_di[1]),
    .MEM_BE(mem_be[1]), .MEM_WE(mem_we[1]), .MEM_REQ(mem_req[1]), .MEM_ACK(mem_ack[1]),
    .ERR(err[1]));

  typedef struct {
    int          sel;
    logic [23:0] addr;
    bit          rd;
    logic [1:0]  wen;
    logic [15:0] wdata;
    logic [15:0] mdi;
    int          dly;
    logic [1:0]  ebe;
    logic [15:0] edo;
    logic [15:0] ebus;
    int          ewp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cef();
    @(posedge CLK);
    while (!CE_F) @(posedge CLK);
    #1;
  endtask

  // Reference rules: lanes and data as seen by the backend and by the CPU.
  function automatic logic [1:0] m_be(input int sel, input bit rd, input logic [1:0] wen);
    if (sel == 1) return 2'b01;
    return rd ? 2'b11 : ~wen;
  endfunction

  function automatic logic [15:0] m_lane(input int sel, input logic [15:0] d);
    return (sel == 1) ? {8'h00, d[7:0]} : d;
  endfunction

  task automatic release_bus(input int sel, input bit keep);
    @(negedge CLK);
    RD_N = 1'b1;
    WE_N = 2'b11;
    if (!keep) cs_n[sel] = 1'b1;
    wait_cef();
    chk("bus_oe_after_release", bus_oe[sel], 1'b0);
    chk("wait_n_after_release", wait_n[sel], 1'b1);
  endtask

  task automatic access(input int sel, input logic [23:0] addr, input bit rd,
                        input logic [1:0] wen, input logic [15:0] wdata,
                        input logic [15:0] mdi, input int dly, input bit keep,
                        input logic [1:0] ebe, input logic [15:0] edo,
                        input logic [15:0] ebus, input int ewp);
    int cef, k_ack, waitp, exp_wp;
    @(negedge CLK);
    cs_n[1-sel] = 1'b1;
    cs_n[sel]   = 1'b0;
    A      = addr;
    BUS_DI = wdata;
    RD_N   = !rd;
    WE_N   = rd ? 2'b11 : wen;
    wait_cef();
    chk("mem_req_start", mem_req[sel], 1'b1);
    chk("wait_n_start", wait_n[sel], 1'b0);
    chk("mem_a", mem_a[sel], addr);
    chk("mem_be", mem_be[sel], ebe);
    chk("mem_we", mem_we[sel], !rd);
    chk("mem_do", mem_do[sel], edo);
    cef = 0;
    k_ack = 0;
    waitp = 0;
    for (int c = 0; c < 200 && waitp == 0; c++) begin
      if (c == dly) begin
        mem_ack[sel] = 1'b1;
        mem_di[sel]  = mdi;
      end
      @(posedge CLK);
      if (CE_F) cef++;
      if (mem_ack[sel] && k_ack == 0) k_ack = CE_F ? cef : cef + 1;
      #1;
      mem_ack[sel] = 1'b0;
      chk("err_quiet", err[sel], 1'b0);
      if (wait_n[sel]) waitp = cef;
    end
    exp_wp = ewp;
    if (exp_wp < 0) begin
      exp_wp = k_ack;
      if (MW[sel] > exp_wp) exp_wp = MW[sel];
      if (exp_wp < 1) exp_wp = 1;
    end
    chk("wait_n_released", wait_n[sel], 1'b1);
    chk("wait_periods", waitp, exp_wp);
    chk("mem_req_dropped", mem_req[sel], 1'b0);
    chk("bus_oe_hold", bus_oe[sel], rd);
    if (rd) last_rd[sel] = ebus;
    chk("bus_do_hold", bus_do[sel], last_rd[sel]);
    release_bus(sel, keep);
    chk("bus_do_stable", bus_do[sel], last_rd[sel]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] rnd;
    int          sel, dly, errc, cef, waitp;
    bit          rd;
    logic [1:0]  wen;
    logic [23:0] addr;
    logic [15:0] wd;

    for (int i = 0; i < 2; i++) begin
      cs_n[i] = 1'b1;
      mem_ack[i] = 1'b0;
      mem_di[i] = 16'h0000;
      last_rd[i] = 16'h0000;
    end

    // sel addr rd wen wdata mdi dly | be do bus wait_periods
    tbl[0] = '{0, 24'h000100, 1'b1, 2'b11, 16'h0000, 16'h1234, 3,  2'b11, 16'h0000, 16'h1234, 1};
    tbl[1] = '{0, 24'h000200, 1'b0, 2'b01, 16'hAB00, 16'h9999, 0,  2'b10, 16'hAB00, 16'h0000, 1};
    tbl[2] = '{0, 24'h000202, 1'b0, 2'b10, 16'h00CD, 16'h9999, 5,  2'b01, 16'h00CD, 16'h0000, 2};
    tbl[3] = '{0, 24'h000204, 1'b0, 2'b00, 16'h5A5A, 16'h9999, 1,  2'b11, 16'h5A5A, 16'h0000, 1};
    tbl[4] = '{1, 24'h000300, 1'b1, 2'b11, 16'h0000, 16'hBEEF, 0,  2'b01, 16'h0000, 16'h00EF, 3};
    tbl[5] = '{1, 24'h000301, 1'b0, 2'b10, 16'h1277, 16'h9999, 9,  2'b01, 16'h0077, 16'h0000, 3};
    tbl[6] = '{1, 24'h000302, 1'b1, 2'b11, 16'h0000, 16'h55AA, 12, 2'b01, 16'h0000, 16'h00AA, 4};

    repeat (6) @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_wait_n", wait_n[i], 1'b1);
      chk("rst_mem_req", mem_req[i], 1'b0);
      chk("rst_bus_oe", bus_oe[i], 1'b0);
      chk("rst_bus_do", bus_do[i], 16'h0000);
      chk("rst_mem_a", mem_a[i], 24'h000000);
      chk("rst_mem_be", mem_be[i], 2'b00);
      chk("rst_mem_we", mem_we[i], 1'b0);
      chk("rst_mem_do", mem_do[i], 16'h0000);
      chk("rst_err", err[i], 1'b0);
    end
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);

    for (int i = 0; i < 7; i++)
      access(tbl[i].sel, tbl[i].addr, tbl[i].rd, tbl[i].wen, tbl[i].wdata, tbl[i].mdi,
             tbl[i].dly, 1'b0, tbl[i].ebe, tbl[i].edo, tbl[i].ebus, tbl[i].ewp);

    // 32-bit read split into four byte cycles on the 8-bit area, CS_N held low.
    for (int i = 0; i < 4; i++) begin
      rnd = 16'($urandom);
      access(1, 24'h000400 + 24'(i), 1'b1, 2'b11, 16'h0000, rnd, int'($urandom_range(0, 3)),
             (i < 3), 2'b01, 16'h0000, {8'h00, rnd[7:0]}, -1);
    end

    // CPU aborts: strobes drop while the backend is still busy.
    @(negedge CLK);
    cs_n[0] = 1'b0; A = 24'h000500; RD_N = 1'b0;
    wait_cef();
    chk("abort_req_start", mem_req[0], 1'b1);
    @(negedge CLK);
    cs_n[0] = 1'b1; RD_N = 1'b1;
    wait_cef();
    wait_cef();
    chk("abort_req_held", mem_req[0], 1'b1);
    mem_ack[0] = 1'b1; mem_di[0] = 16'hDEAD;
    @(posedge CLK);
    #1;
    mem_ack[0] = 1'b0;
    chk("abort_req_dropped", mem_req[0], 1'b0);
    wait_cef();
    chk("abort_wait_n", wait_n[0], 1'b1);
    chk("abort_bus_oe", bus_oe[0], 1'b0);
    chk("abort_bus_do_kept", bus_do[0], last_rd[0]);

    // Reset in the middle of REQ, then a stray acknowledge.
    @(negedge CLK);
    cs_n[0] = 1'b0; A = 24'h000600; RD_N = 1'b0;
    wait_cef();
    chk("rstmid_req", mem_req[0], 1'b1);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk("rstmid_wait_n", wait_n[0], 1'b1);
    chk("rstmid_mem_req", mem_req[0], 1'b0);
    chk("rstmid_bus_oe", bus_oe[0], 1'b0);
    cs_n[0] = 1'b1; RD_N = 1'b1;
    RST_N = 1'b1;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(posedge CLK);
    #1;
    mem_ack[0] = 1'b1; mem_di[0] = 16'h7777;
    mem_ack[1] = 1'b1; mem_di[1] = 16'h7777;
    @(posedge CLK);
    #1;
    mem_ack[0] = 1'b0;
    mem_ack[1] = 1'b0;
    wait_cef();
    chk("late_ack_req", mem_req[0], 1'b0);
    chk("late_ack_wait_n", wait_n[0], 1'b1);
    chk("late_ack_bus_do", bus_do[0], 16'h0000);
    chk("late_ack_bus_oe", bus_oe[0], 1'b0);
    chk("late_ack_bus_do8", bus_do[1], 16'h0000);

`ifdef EXT_TGT_TIMEOUT_EN
    @(negedge CLK);
    cs_n[0] = 1'b0; A = 24'h000700; RD_N = 1'b0;
    wait_cef();
    errc = 0; cef = 0; waitp = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      if (CE_F) cef++;
      #1;
      if (err[0]) errc++;
      if (wait_n[0] && waitp == 0) waitp = cef;
    end
    chk("to_err_pulses", errc, 1);
    chk("to_wait_periods", waitp, 4);
    chk("to_bus_do", bus_do[0], 16'hFFFF);
    chk("to_bus_oe", bus_oe[0], 1'b1);
    chk("to_mem_req", mem_req[0], 1'b0);
    mem_ack[0] = 1'b1; mem_di[0] = 16'h4321;
    @(posedge CLK);
    #1;
    mem_ack[0] = 1'b0;
    chk("to_late_ack_bus_do", bus_do[0], 16'hFFFF);
    last_rd[0] = 16'hFFFF;
    release_bus(0, 1'b0);
`else
    @(negedge CLK);
    cs_n[0] = 1'b0; A = 24'h000800; RD_N = 1'b0;
    wait_cef();
    repeat (6) wait_cef();
    chk("stall_req_held", mem_req[0], 1'b1);
    chk("stall_wait_n_low", wait_n[0], 1'b0);
    chk("stall_no_err", err[0], 1'b0);
    mem_ack[0] = 1'b1; mem_di[0] = 16'h0F0F;
    @(posedge CLK);
    #1;
    mem_ack[0] = 1'b0;
    wait_cef();
    chk("stall_wait_n_rel", wait_n[0], 1'b1);
    chk("stall_bus_do", bus_do[0], 16'h0F0F);
    chk("stall_bus_oe", bus_oe[0], 1'b1);
    last_rd[0] = 16'h0F0F;
    release_bus(0, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
      sel  = int'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       wen = 2'b01;
        1:       wen = 2'b10;
        default: wen = 2'b00;
      endcase
      addr = 24'($urandom);
      wd   = 16'($urandom);
      rnd  = 16'($urandom);
      dly  = int'($urandom_range(0, 8));
      access(sel, addr, rd, wen, wd, rnd, dly, 1'($urandom_range(0, 1)),
             m_be(sel, rd, wen), m_lane(sel, wd), m_lane(sel, rnd), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sh_ext_bus_target.md
Name: sh_ext_bus_target

Overview:
- Responder on the SH7034 external bus: decodes one chip-select area driven by the on-chip bus controller and serves the access.
- Accesses are byte-lane reads/writes, optionally stretched through the WAIT_N handshake.
- Converts each external strobe cycle into a single request/acknowledge transaction on a simple backend memory/peripheral port.
- Instantiated in the top level next to the CPU core, one instance per emulated area (ROM, work RAM, I/O).

Parameters:
- BUS16, 1, 1 = 16-bit area (both lanes valid); 0 = 8-bit area (data on D7:0 only, lane 0).
- MIN_WAIT, 0, minimum CE_F periods WAIT_N stays low after an access starts (0..7).
- TIMEOUT, 255, CE_F periods without MEM_ACK before forced completion (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, synchronous, active-low
- CE_R  in  1  rising-phase clock enable of the bus clock
- CE_F  in  1  falling-phase clock enable of the bus clock
- A  in  24  external address
- BUS_DI  in  16  write data from CPU (CPU DO)
- BUS_DO  out  16  read data to CPU (CPU DI)
- BUS_OE  out  1  BUS_DO drive enable
- CS_N  in  1  area chip select
- RD_N  in  1  read strobe
- WE_N  in  2  write strobes; [1] = D15:8, [0] = D7:0
- WAIT_N  out  1  wait request to CPU
- MEM_A  out  24  backend address
- MEM_DO  out  16  backend write data
- MEM_DI  in  16  backend read data
- MEM_BE  out  2  backend byte enables
- MEM_WE  out  1  backend write
- MEM_REQ  out  1  backend request, level
- MEM_ACK  in  1  backend acknowledge, single-cycle pulse
- ERR  out  1  timeout pulse (optional feature only; tied 0 otherwise)

Behaviour:
- One clock, CLK. Reset is synchronous and active-low (RST_N). All state advances only on CE_F, except the WAIT_N release described below.
- Reset values: BUS_DO=0, BUS_OE=0, WAIT_N=1, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_A=0, MEM_DO=0, ERR=0, state=IDLE, wait counter=0.
- Reset asserted mid-access: return to IDLE immediately. Any pending MEM_ACK is ignored and WAIT_N is released.
- Strobe active: STB = !CS_N & (!RD_N | WE_N != 2'b11).
- State IDLE, on CE_F with STB:
  - Latch MEM_A=A, MEM_WE=(RD_N==1), MEM_DO=BUS_DI.
  - MEM_BE = BUS16 ? (write ? ~WE_N : 2'b11) : 2'b01.
  - In 8-bit mode MEM_DO={8'h00,BUS_DI[7:0]}.
  - Set MEM_REQ=1, WAIT_N=0, wait counter=MIN_WAIT. Go to REQ.
  - WAIT_N therefore falls half a cycle after T1 and is valid at the CPU's first TW CE_R.
- State REQ, every CLK:
  - MEM_ACK: MEM_REQ=0. On read, capture MEM_DI (8-bit: {8'h00,MEM_DI[7:0]}) into BUS_DO.
  - If the acknowledge arrives on a CE_F, the same CE_F also decrements the wait counter.
  - On CE_F: decrement the wait counter while it is nonzero.
  - When ack has been seen and the counter is 0 at a CE_F: WAIT_N=1, BUS_OE=!MEM_WE, go to HOLD.
  - Earliest completion with MIN_WAIT=0 and ack in the same cycle as the request: WAIT_N low for exactly one CE_F period.
- State HOLD:
  - BUS_DO is held stable.
  - On CE_F with RD_N=1 and WE_N=2'b11: BUS_OE=0, go to IDLE.
  - CS_N may stay low. The CPU splits long/word accesses across consecutive cycles without releasing CS, so end of access is detected on the strobes, not on CS_N.
  - A new strobe is only recognised after IDLE has been re-entered for at least one CE_F.
- Strobes dropped while in REQ (CPU aborted, e.g. wait area configured 0): keep MEM_REQ until ack, discard the data, then go to IDLE without HOLD.
- MEM_ACK outside REQ: ignored.
- BUS_OE never asserts for writes.

Optional Feature:
- Macro EXT_TGT_TIMEOUT_EN.
- Defined: a counter runs in REQ on CE_F. When it reaches TIMEOUT without ack:
  - Force completion with BUS_DO=16'hFFFF and MEM_REQ=0.
  - Pulse ERR for one CLK.
  - Proceed exactly as if ack had been received.
  - A late MEM_ACK is ignored.
- Undefined: no counter; ERR is tied 0. REQ waits indefinitely.

Decomposition:
- Shared package SH7034_PKG holds:
  - ExtTgtState_t enum {IDLE, REQ, HOLD};
  - the EXT_TGT_FF_DATA constant 16'hFFFF.
- Single module. No sub-module is warranted; the timeout counter stays inline.

Test Plan:
- Word read, BUS16=1, MIN_WAIT=0, MEM_ACK 3 CLKs after MEM_REQ, MEM_DI=16'h1234, A=24'h000100:
  - MEM_A=24'h000100, MEM_BE=11, MEM_WE=0.
  - WAIT_N releases on the next CE_F after ack.
  - BUS_DO=16'h1234 with BUS_OE=1 until RD_N rises.
- Upper-byte write, WE_N=2'b01, BUS_DI=16'hAB00:
  - MEM_BE=2'b10, MEM_WE=1, MEM_DO=16'hAB00.
  - BUS_OE stays 0.
- 8-bit area (BUS16=0), 32-bit CPU read split into four byte cycles with CS_N held low and RD_N toggling:
  - Four MEM_REQs with A+0..A+3 and MEM_BE=01.
  - BUS_DO upper byte = 0 on each.
- MIN_WAIT=3, ack in the same cycle as the request -> WAIT_N low for exactly 3 CE_F periods.
- RST_N low while in REQ -> next CLK: WAIT_N=1, MEM_REQ=0, BUS_OE=0; an ack arriving later has no effect.
- EXT_TGT_TIMEOUT_EN, TIMEOUT=4, no ack -> after 4 CE_F: ERR pulses once, BUS_DO=16'hFFFF, WAIT_N=1.
